// File: rtl/krnl_cam_rtl_result_packer.sv
// krnl_cam_rtl_result_packer
// Packs per-cycle CAM search results into AXI4-Stream beats and buffers them
// in a small first-word-fall-through FIFO (registered output) for write-back.
// Optional macro CAM_PACKER_STATS_EN: saturating hit/miss counters. Without
// it, hit_cnt and miss_cnt are tied to 0.
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   s_tvalid, s_tdata        one search result per valid cycle (low RESULT_WIDTH bits kept)
//   update_all_end           qualifies the valid beat as update-all completion (discarded)
//   flush                    close the current beat with tlast
//   m_tvalid, m_tready,
//   m_tdata, m_tkeep, m_tlast AXI4-Stream output
//   prog_full                FIFO occupancy >= PROG_FULL_THRESH
//   overflow                 sticky: a completed beat was dropped
//   update_done_cnt          update-all completion count (wraps)
//   hit_cnt, miss_cnt        result statistics
module krnl_cam_rtl_result_packer #(
  parameter int unsigned C_DATA_WIDTH     = 512,
  parameter int unsigned RESULT_WIDTH     = 32,
  parameter int unsigned INDEX_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned PROG_FULL_THRESH = 6
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_tvalid,
  input  logic [C_DATA_WIDTH-1:0]   s_tdata,
  input  logic                      update_all_end,
  input  logic                      flush,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [C_DATA_WIDTH-1:0]   m_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_tkeep,
  output logic                      m_tlast,
  output logic                      prog_full,
  output logic                      overflow,
  output logic [15:0]               update_done_cnt,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt
);

  localparam int unsigned LANES      = C_DATA_WIDTH / RESULT_WIDTH;
  localparam int unsigned KEEP_WIDTH = C_DATA_WIDTH / 8;
  localparam int unsigned LANE_BYTES = RESULT_WIDTH / 8;
  localparam int unsigned LANE_CW    = $clog2(LANES + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W    = C_DATA_WIDTH + KEEP_WIDTH + 1;

  localparam logic [0:0] ST_FILL       = 1'b0;
  localparam logic [0:0] ST_FLUSH_WAIT = 1'b1;

  logic [0:0]              state, state_next;
  logic [LANE_CW-1:0]      lane_cnt, lane_cnt_next, lanes_after;
  logic [C_DATA_WIDTH-1:0] acc, acc_next, wr_data, closed_data;
  logic [KEEP_WIDTH-1:0]   closed_keep;
  logic [ENTRY_W-1:0]      closed_entry, push_entry, pend_entry, pend_entry_next;
  logic                    pend_valid, pend_valid_next;
  logic                    accept, close_full, do_flush, close;
  logic                    pop, space, load, push, drop;
  logic [OCC_W-1:0]        mem_cnt, mem_cnt_next, occ, occ_next;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
  logic                    unused_tdata;

  assign unused_tdata = ^s_tdata[C_DATA_WIDTH-1:RESULT_WIDTH];

  // Lane write, beat close, FIFO push arbitration and FSM next state.
  always_comb begin
    state_next      = state;
    accept          = s_tvalid && !update_all_end;
    lanes_after     = lane_cnt + LANE_CW'(accept);
    wr_data         = acc;
    closed_data     = '0;
    closed_keep     = '0;
    push            = 1'b0;
    drop            = 1'b0;
    pend_valid_next = pend_valid;
    pend_entry_next = pend_entry;

    for (int k = 0; k < LANES; k++) begin
      if (accept && lane_cnt == LANE_CW'(k))
        wr_data[k*RESULT_WIDTH +: RESULT_WIDTH] = s_tdata[RESULT_WIDTH-1:0];
    end

    // Closed beat: written lanes kept and enabled, the rest padded with ones.
    closed_data = wr_data;
    for (int k = 0; k < LANES; k++) begin
      if (LANE_CW'(k) < lanes_after)
        closed_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
      else
        closed_data[k*RESULT_WIDTH +: RESULT_WIDTH] = '1;
    end

    // A flush arriving while one is already held merges into it.
    do_flush     = flush && !pend_valid;
    close_full   = (lanes_after == LANE_CW'(LANES));
    close        = close_full || do_flush;
    closed_entry = {do_flush, closed_keep, closed_data};
    push_entry   = closed_entry;

    // Occupancy counts the output register; a same-cycle pop frees a slot.
    occ   = mem_cnt + OCC_W'(m_tvalid);
    pop   = m_tvalid && m_tready;
    space = (occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);
    load  = (mem_cnt != '0) && (!m_tvalid || m_tready);

    // The held flush beat is older and wins the single push slot; a full
    // beat completing in that cycle has nowhere to go and is dropped.
    if (pend_valid) begin
      if (space) begin
        push            = 1'b1;
        push_entry      = pend_entry;
        pend_valid_next = 1'b0;
      end
      if (close_full) drop = 1'b1;
    end else if (close) begin
      if (space) begin
        push = 1'b1;
      end else if (do_flush) begin
        pend_valid_next = 1'b1;
        pend_entry_next = closed_entry;
      end else begin
        drop = 1'b1;
      end
    end

    case (state)
      ST_FILL:       if (close && !space) state_next = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: if (space)           state_next = ST_FILL;
      default:                            state_next = ST_FILL;
    endcase

    lane_cnt_next = close ? '0 : lanes_after;
    acc_next      = close ? '0 : wr_data;
    mem_cnt_next  = mem_cnt + OCC_W'(push) - OCC_W'(load);
    occ_next      = occ - OCC_W'(pop) + OCC_W'(push);
  end

  // State, accumulator, FIFO control, output register and status.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state           <= ST_FILL;
      lane_cnt        <= '0;
      acc             <= '0;
      pend_valid      <= 1'b0;
      pend_entry      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      mem_cnt         <= '0;
      m_tvalid        <= 1'b0;
      m_tdata         <= '0;
      m_tkeep         <= '0;
      m_tlast         <= 1'b0;
      prog_full       <= 1'b0;
      overflow        <= 1'b0;
      update_done_cnt <= '0;
    end else begin
      state      <= state_next;
      lane_cnt   <= lane_cnt_next;
      acc        <= acc_next;
      pend_valid <= pend_valid_next;
      pend_entry <= pend_entry_next;
      mem_cnt    <= mem_cnt_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) begin
        {m_tlast, m_tkeep, m_tdata} <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
        m_tvalid <= 1'b1;
      end else if (pop) begin
        m_tvalid <= 1'b0;
      end
      prog_full <= (occ_next >= OCC_W'(PROG_FULL_THRESH));
      if (drop) overflow <= 1'b1;
      if (s_tvalid && update_all_end) update_done_cnt <= update_done_cnt + 16'd1;
    end
  end

  // Beat storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

`ifdef CAM_PACKER_STATS_EN
  logic is_miss;
  assign is_miss = &s_tdata[INDEX_WIDTH:0];

  // Saturating hit/miss counters over accepted results.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (is_miss) begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end else begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
